simt_load_store_unit: RTL

- Responder end of the datapath's load/store interface. Serves instruction fetch, scalar data, and per-thread vector data requests.
- All traffic is serialized onto one shared word-wide memory port, which has a request/ready handshake.
- Holds the fetched instruction and loaded data stable until it pulses iHit. iHit tells the datapath the current instruction is complete and the PC may advance.

---
 rtl/simt_load_store_unit_pkg.sv | 31 +++
 rtl/simt_load_store_unit_if.sv | 25 ++
 rtl/simt_load_store_unit_lane_sequencer.sv | 28 ++
 rtl/simt_load_store_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/simt_load_store_unit_pkg.sv
// Shared types and constants for the SIMT load/store unit.
//   lsu_state_t   : sequencing states of the unit
//   is_vector_op  : true when an instruction opcode is a vector memory op
package simt_load_store_unit_pkg;

  localparam int unsigned THREADS_DEF = 4;
  localparam int unsigned WORD_W_DEF  = 32;
  localparam int unsigned OPC_W       = 6;
  localparam int unsigned PERF_W      = 32;

  localparam logic [OPC_W-1:0] OPC_VLW  = 6'h32;
  localparam logic [OPC_W-1:0] OPC_VLWO = 6'h33;
  localparam logic [OPC_W-1:0] OPC_VSW  = 6'h3A;
  localparam logic [OPC_W-1:0] OPC_VSWO = 6'h3B;

  typedef enum logic [2:0] {
    IFETCH = 3'd0,
    EXEC   = 3'd1,
    SDATA  = 3'd2,
    VDATA  = 3'd3,
    DONE   = 3'd4,
    HALT   = 3'd5
  } lsu_state_t;

  // Opcode field is the top OPC_W bits of the instruction word.
  function automatic logic is_vector_op(input logic [OPC_W-1:0] opc);
    return (opc == OPC_VLW) || (opc == OPC_VLWO) ||
           (opc == OPC_VSW) || (opc == OPC_VSWO);
  endfunction

endpackage

// File: rtl/simt_load_store_unit_if.sv
// Shared word-wide memory port with request/ready handshake.
//   master : request side (drives mem_ren, mem_wen, mem_addr, mem_wdata)
//   slave  : memory side  (drives mem_rdata, mem_ready)
interface simt_load_store_unit_if
  import simt_load_store_unit_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF
);
  logic              mem_ren;
  logic              mem_wen;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/simt_load_store_unit_lane_sequencer.sv
// Combinational next-set-bit finder over the lane mask.
//   i_mask  : lane mask
//   i_cur   : current lane index (signed; -1 searches from lane 0)
//   o_next  : lowest set lane strictly above i_cur
//   o_valid : such a lane exists
module simt_load_store_unit_lane_sequencer #(
  parameter int unsigned THREADS = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [THREADS-1:0]      i_mask,
  input  logic signed [IDX_W:0]   i_cur,
  output logic [IDX_W-1:0]        o_next,
  output logic                    o_valid
);

  // Scan downwards so the lowest qualifying lane is the last one written.
  always_comb begin
    o_next  = '0;
    o_valid = 1'b0;
    for (int i = int'(THREADS) - 1; i >= 0; i--) begin
      if (i_mask[i] && ($signed((IDX_W+1)'(i)) > i_cur)) begin
        o_valid = 1'b1;
        o_next  = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/simt_load_store_unit.sv
// SIMT load/store unit: serves instruction fetch, scalar and per-lane vector
// data accesses for the datapath over one shared memory port, and pulses iHit
// when the current instruction and its data access are complete.
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   instReq, iaddr           fetch request and PC
//   iload, isVector, iHit    latched instruction, vector-op flag, completion pulse
//   readReq, writeReq        data access request decoded from iload
//   sdaddr/sdstore/sdload    scalar data address, store data, load result
//   vdaddr/vdstore/vdload    per-lane (lane i at [i*WORD_W +: WORD_W])
//   lane_mask, dhalt         active vector lanes, datapath halted
//   mem                      shared memory port (master side)
// Optional: define LSU_PERF_CNT_EN to add saturating perf_fetches,
// perf_data_accs and perf_stall_cycles counters.
module simt_load_store_unit
  import simt_load_store_unit_pkg::*;
#(
  parameter int unsigned THREADS = THREADS_DEF,
  parameter int unsigned WORD_W  = WORD_W_DEF
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      instReq,
  input  logic [WORD_W-1:0]         iaddr,
  output logic [WORD_W-1:0]         iload,
  output logic                      iHit,
  input  logic                      readReq,
  input  logic                      writeReq,
  output logic                      isVector,
  input  logic [WORD_W-1:0]         sdaddr,
  input  logic [WORD_W-1:0]         sdstore,
  output logic [WORD_W-1:0]         sdload,
  input  logic [THREADS*WORD_W-1:0] vdaddr,
  input  logic [THREADS*WORD_W-1:0] vdstore,
  output logic [THREADS*WORD_W-1:0] vdload,
  input  logic [THREADS-1:0]        lane_mask,
  input  logic                      dhalt,
  simt_load_store_unit_if.master    mem
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]         perf_fetches,
  output logic [PERF_W-1:0]         perf_data_accs,
  output logic [PERF_W-1:0]         perf_stall_cycles
`endif
);

  localparam int unsigned IDX_W = (THREADS > 1) ? $clog2(THREADS) : 1;

  lsu_state_t          r_state, w_state_nxt;
  logic [WORD_W-1:0]   r_iload, w_iload_nxt;
  logic                r_is_vec, w_is_vec_nxt;
  logic [WORD_W-1:0]   r_sdload, w_sdload_nxt;
  logic [WORD_W-1:0]   r_lane_load [THREADS];
  logic [WORD_W-1:0]   w_lane_load_nxt [THREADS];
  logic                r_ihit, w_ihit_nxt;
  logic                r_ren, w_ren_nxt;
  logic                r_wen, w_wen_nxt;
  logic [WORD_W-1:0]   r_addr, w_addr_nxt;
  logic [WORD_W-1:0]   r_wdata, w_wdata_nxt;
  logic                r_op_read, w_op_read_nxt;
  logic [THREADS-1:0]  r_lane_mask, w_lane_mask_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;

  logic [WORD_W-1:0]   w_lane_addr  [THREADS];
  logic [WORD_W-1:0]   w_lane_wdata [THREADS];
  logic [THREADS-1:0]  w_seq_mask;
  logic signed [IDX_W:0] w_seq_cur;
  logic [IDX_W-1:0]    w_seq_next;
  logic                w_seq_valid;

  // Unpack lane buses and pack lane load results.
  for (genvar g = 0; g < THREADS; g++) begin : g_lane
    assign w_lane_addr[g]  = vdaddr[g*WORD_W +: WORD_W];
    assign w_lane_wdata[g] = vdstore[g*WORD_W +: WORD_W];
    assign vdload[g*WORD_W +: WORD_W] = r_lane_load[g];
  end

  // In EXEC search the live mask from -1; in VDATA continue from the held mask.
  assign w_seq_mask = (r_state == EXEC) ? lane_mask : r_lane_mask;
  assign w_seq_cur  = (r_state == EXEC) ? '1 : $signed({1'b0, r_idx});

  simt_load_store_unit_lane_sequencer #(
    .THREADS (THREADS),
    .IDX_W   (IDX_W)
  ) u_lane_sequencer (
    .i_mask  (w_seq_mask),
    .i_cur   (w_seq_cur),
    .o_next  (w_seq_next),
    .o_valid (w_seq_valid)
  );

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_iload_nxt     = r_iload;
    w_is_vec_nxt    = r_is_vec;
    w_sdload_nxt    = r_sdload;
    w_lane_load_nxt = r_lane_load;
    w_ihit_nxt      = 1'b0;
    w_ren_nxt       = r_ren;
    w_wen_nxt       = r_wen;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_op_read_nxt   = r_op_read;
    w_lane_mask_nxt = r_lane_mask;
    w_idx_nxt       = r_idx;

    case (r_state)
      IFETCH: begin
        if (r_ren) begin
          // An outstanding fetch always finishes before halting.
          if (mem.mem_ready) begin
            w_ren_nxt    = 1'b0;
            w_iload_nxt  = mem.mem_rdata;
            w_is_vec_nxt = is_vector_op(mem.mem_rdata[WORD_W-1 -: OPC_W]);
            w_state_nxt  = dhalt ? HALT : EXEC;
          end
        end else if (dhalt) begin
          w_state_nxt = HALT;
        end else if (instReq) begin
          w_ren_nxt  = 1'b1;
          w_addr_nxt = iaddr;
        end
      end

      EXEC: begin
        // Read wins when both requests are present.
        w_op_read_nxt = readReq;
        if (readReq || writeReq) begin
          if (r_is_vec) begin
            w_lane_mask_nxt = lane_mask;
            if (w_seq_valid) begin
              w_idx_nxt   = w_seq_next;
              w_ren_nxt   = readReq;
              w_wen_nxt   = !readReq;
              w_addr_nxt  = w_lane_addr[w_seq_next];
              w_wdata_nxt = w_lane_wdata[w_seq_next];
              w_state_nxt = VDATA;
            end else begin
              w_ihit_nxt  = 1'b1;
              w_state_nxt = DONE;
            end
          end else begin
            w_ren_nxt   = readReq;
            w_wen_nxt   = !readReq;
            w_addr_nxt  = sdaddr;
            w_wdata_nxt = sdstore;
            w_state_nxt = SDATA;
          end
        end else begin
          w_ihit_nxt  = 1'b1;
          w_state_nxt = DONE;
        end
      end

      SDATA: begin
        if (mem.mem_ready) begin
          w_ren_nxt = 1'b0;
          w_wen_nxt = 1'b0;
          if (r_op_read) begin
            w_sdload_nxt = mem.mem_rdata;
          end
          w_ihit_nxt  = 1'b1;
          w_state_nxt = DONE;
        end
      end

      VDATA: begin
        if (mem.mem_ready) begin
          if (r_op_read) begin
            w_lane_load_nxt[r_idx] = mem.mem_rdata;
          end
          // Chain straight into the next active lane without dropping the request.
          if (w_seq_valid) begin
            w_idx_nxt   = w_seq_next;
            w_addr_nxt  = w_lane_addr[w_seq_next];
            w_wdata_nxt = w_lane_wdata[w_seq_next];
          end else begin
            w_ren_nxt   = 1'b0;
            w_wen_nxt   = 1'b0;
            w_ihit_nxt  = 1'b1;
            w_state_nxt = DONE;
          end
        end
      end

      DONE: begin
        w_state_nxt = dhalt ? HALT : IFETCH;
      end

      HALT: begin
        w_state_nxt = HALT;
      end

      default: begin
        w_state_nxt = IFETCH;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= IFETCH;
      r_iload     <= '0;
      r_is_vec    <= 1'b0;
      r_sdload    <= '0;
      for (int k = 0; k < int'(THREADS); k++) begin
        r_lane_load[k] <= '0;
      end
      r_ihit      <= 1'b0;
      r_ren       <= 1'b0;
      r_wen       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_op_read   <= 1'b0;
      r_lane_mask <= '0;
      r_idx       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_iload     <= w_iload_nxt;
      r_is_vec    <= w_is_vec_nxt;
      r_sdload    <= w_sdload_nxt;
      r_lane_load <= w_lane_load_nxt;
      r_ihit      <= w_ihit_nxt;
      r_ren       <= w_ren_nxt;
      r_wen       <= w_wen_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_op_read   <= w_op_read_nxt;
      r_lane_mask <= w_lane_mask_nxt;
      r_idx       <= w_idx_nxt;
    end
  end

  assign iload         = r_iload;
  assign isVector      = r_is_vec;
  assign sdload        = r_sdload;
  assign iHit          = r_ihit;
  assign mem.mem_ren   = r_ren;
  assign mem.mem_wen   = r_wen;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;

`ifdef LSU_PERF_CNT_EN
  logic [PERF_W-1:0] r_perf_fetches, r_perf_data_accs, r_perf_stall;
  logic              w_req_active, w_fetch_done, w_data_done, w_stall;

  assign w_req_active = r_ren || r_wen;
  assign w_fetch_done = (r_state == IFETCH) && r_ren && mem.mem_ready;
  assign w_data_done  = ((r_state == SDATA) || (r_state == VDATA)) &&
                        w_req_active && mem.mem_ready;
  assign w_stall      = w_req_active && !mem.mem_ready;

  // Saturating event counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_perf_fetches   <= '0;
      r_perf_data_accs <= '0;
      r_perf_stall     <= '0;
    end else begin
      if (w_fetch_done && (r_perf_fetches != '1)) begin
        r_perf_fetches <= r_perf_fetches + PERF_W'(1);
      end
      if (w_data_done && (r_perf_data_accs != '1)) begin
        r_perf_data_accs <= r_perf_data_accs + PERF_W'(1);
      end
      if (w_stall && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + PERF_W'(1);
      end
    end
  end

  assign perf_fetches      = r_perf_fetches;
  assign perf_data_accs    = r_perf_data_accs;
  assign perf_stall_cycles = r_perf_stall;
`endif

endmodule
